oled_spi_receiver: RTL and testbench
====================================

// Module: oled_spi_receiver
// PURPOSE
//   Receiving end of the OLED SPI+DC link: snoops CS/SCLK/SDO/DC as driven by the OLED driver.
//   Rebuilds bytes, decodes page/column commands and emits pixel-column writes (page, col, byte).
//   Feeds a framebuffer/char-cell checker, giving on-chip readback and a bench display model.
//   SCLK is asynchronous to CLK and oversampled.
// PARAMETERS
//   SYNC_STAGES  2    flops per input synchronizer (min 2)
//   COLS         128  columns per page; column counter wraps at COLS-1
//   PAGES        4    pages per frame; page counter wraps at PAGES-1
// PORTS
//   CLK        in   1  system clock; all logic on rising edge
//   RST        in   1  synchronous reset, active-high
//   CS         in   1  SPI chip select, active-low, async
//   SCLK       in   1  SPI clock, idle high, async
//   SDO        in   1  SPI data, MSB first, sampled on SCLK rising edge, async
//   DC         in   1  0 = command byte, 1 = data byte; sampled with bit 0 (last bit)
//   wr_en      out  1  one-cycle pulse: data byte written at wr_page/wr_col
//   wr_page    out  2  page of current write
//   wr_col     out  7  column of current write
//   wr_data    out  8  pixel-column byte (bit0 = top row of page)
//   cmd_valid  out  1  one-cycle pulse: command byte received
//   cmd_byte   out  8  command byte value, held until next cmd_valid
//   frame_done out  1  one-cycle pulse with wr_en at page PAGES-1, col COLS-1
//   err_abort  out  1  one-cycle pulse: CS rose with 1..7 bits shifted
// BEHAVIOUR
//   Reset: all outputs 0; page=0, col=0, bit count=0, arg_pending=0, FSM=IDLE.
//   Input timing: SCLK high and low each >= 3 CLK periods; slower edges are not supported.
//   Sync: each input through SYNC_STAGES flops, plus one flop for SCLK edge detect.
//   Deser FSM:
//     IDLE : CS_s=1; bit count=0; CS_s falling -> SHIFT.
//     SHIFT: per SCLK_s rising edge, shift SDO_s in LSB; bit count+1.
//            8th bit -> byte_valid pulse with DC_s; bit count=0; stay in SHIFT.
//            CS_s rising -> IDLE; if bit count!=0, pulse err_abort and discard partial byte.
//   Latency: wr_en/cmd_valid asserted exactly SYNC_STAGES+2 CLK after 8th SCLK rise at pin.
//   Decoder (on byte_valid):
//     DC=1: wr_en=1, wr_data=byte, wr_page/wr_col=current.
//           col+1 next cycle; col=COLS-1 -> col=0, page+1 mod PAGES.
//           Clears arg_pending.
//     DC=0: cmd_valid=1, cmd_byte=byte.
//       arg_pending=1    -> page=byte[1:0]; arg_pending=0; col unchanged.
//       0x22             -> arg_pending=1.
//       0x00-0x0F        -> col[3:0]=byte[3:0].
//       0x10-0x17        -> col[6:4]=byte[2:0].
//       0xB0-0xB3        -> page=byte[1:0].
//       other            -> cmd_valid only, no state change.
//   arg_pending survives CS deassert; the driver toggles CS per byte.
//   Simultaneous byte_valid and CS rise: byte is accepted; err_abort not pulsed.
//   RST mid-byte: partial byte dropped; no pulses in the RST cycle or the cycle after.
// STRUCTURE
//   oled_pkg: OLED_CMD_SET_PAGE=8'h22, OLED_CMD_COL_LO=4'h0, OLED_CMD_COL_HI=4'h1,
//             OLED_CMD_PAGE_BASE=5'b10110, COLS/PAGES defaults.
//   Sub-module oled_spi_deser: synchronizers + edge detect + IDLE/SHIFT FSM.
//     Outputs byte_valid, byte, dc, err_abort.
//   This module: address decoder, page/col counters, output registers.
// TESTING
//   1 Send cmd 22,02,00,10, then data A5 with SCLK=8 CLK periods.
//     -> cmd_valid x4; wr_en with page=2, col=0, data=A5; latency SYNC_STAGES+2.
//   2 Full frame: 512 data bytes from page0 col0.
//     -> col wraps 127->0, page 0..3; frame_done with 512th wr_en only; page=0, col=0 after.
//   3 CS rises after 5 bits, then a full byte 3C with DC=1.
//     -> err_abort once; no wr_en for partial; wr_data=3C.
//   4 Cmd 05, then 13, then data 11.
//     -> write at col 0x35; cmd 0xB1 then data -> page=1, col unchanged.
//   5 Cmd 22 then data 7E.
//     -> arg_pending cleared; 7E written at prior page/col; next cmd 02 is not taken as page.
//   6 RST pulse mid-byte (bit 4); resend a full byte.
//     -> no wr_en/err_abort for the aborted byte; next byte decodes at page0 col0.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED SPI receiver: command encodings,
// geometry defaults and the deserializer state type.
package oled_pkg;

  localparam int OLED_COLS  = 128;
  localparam int OLED_PAGES = 4;
  localparam int PAGE_W     = 2;
  localparam int COL_W      = 7;

  localparam logic [7:0] OLED_CMD_SET_PAGE  = 8'h22;
  localparam logic [3:0] OLED_CMD_COL_LO    = 4'h0;
  localparam logic [3:0] OLED_CMD_COL_HI    = 4'h1;
  localparam logic [4:0] OLED_CMD_PAGE_BASE = 5'b10110;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/oled_spi_deser.sv
// Oversampling SPI deserializer: synchronizes CS/SCLK/SDO/DC into CLK,
// detects SCLK rising edges and rebuilds MSB-first bytes framed by CS.
module oled_spi_deser
  import oled_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cs,
  input  logic         sclk,
  input  logic         sdo,
  input  logic         dc,
  output logic         byte_valid,
  output logic [7:0]   rx_byte,
  output logic         byte_dc,
  output logic         err_abort,
  output deser_state_t state
);

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdo_sync, dc_sync;
  logic                   cs_d, sclk_d;
  logic [2:0]             bit_cnt;
  logic [6:0]             shreg;

  logic cs_s, sclk_s, sdo_s, dc_s, sclk_rise, cs_fall;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdo_s     = sdo_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  // cs_d resets low so a CS already low when reset releases is not taken as a new frame.
  assign cs_fall   = cs_d & ~cs_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync    <= '0;
      sclk_sync  <= '1;
      sdo_sync   <= '0;
      dc_sync    <= '0;
      cs_d       <= 1'b0;
      sclk_d     <= 1'b1;
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      byte_valid <= 1'b0;
      rx_byte    <= 8'd0;
      byte_dc    <= 1'b0;
      err_abort  <= 1'b0;
    end else begin
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdo_sync   <= {sdo_sync[SYNC_STAGES-2:0], sdo};
      dc_sync    <= {dc_sync[SYNC_STAGES-2:0], dc};
      cs_d       <= cs_s;
      sclk_d     <= sclk_s;
      byte_valid <= 1'b0;
      err_abort  <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_cnt <= 3'd0;
          if (cs_fall) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            shreg <= {shreg[5:0], sdo_s};
            if (bit_cnt == 3'd7) begin
              byte_valid <= 1'b1;
              rx_byte    <= {shreg, sdo_s};
              byte_dc    <= dc_s;
              bit_cnt    <= 3'd0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          // A byte completing in the same cycle CS rises is kept, not aborted.
          if (cs_s) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            if (sclk_rise ? (bit_cnt != 3'd7) : (bit_cnt != 3'd0)) err_abort <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/oled_spi_receiver.sv
// Receiving end of the OLED SPI+DC link: decodes page/column commands and
// turns data bytes into addressed pixel-column writes.
module oled_spi_receiver
  import oled_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = OLED_COLS,
  parameter int PAGES       = OLED_PAGES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              SDO,
  input  logic              DC,
  output logic              wr_en,
  output logic [PAGE_W-1:0] wr_page,
  output logic [COL_W-1:0]  wr_col,
  output logic [7:0]        wr_data,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte,
  output logic              frame_done,
  output logic              err_abort,
  output deser_state_t      deser_state
);

  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);

  logic              byte_valid, byte_dc, deser_err;
  logic [7:0]        rx_byte;
  logic [PAGE_W-1:0] page;
  logic [COL_W-1:0]  col;
  logic              arg_pending;

  oled_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk        (CLK),
    .rst        (RST),
    .cs         (CS),
    .sclk       (SCLK),
    .sdo        (SDO),
    .dc         (DC),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .byte_dc    (byte_dc),
    .err_abort  (deser_err),
    .state      (deser_state)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_en       <= 1'b0;
      wr_page     <= '0;
      wr_col      <= '0;
      wr_data     <= 8'd0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= 8'd0;
      frame_done  <= 1'b0;
      err_abort   <= 1'b0;
      page        <= '0;
      col         <= '0;
      arg_pending <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      err_abort  <= deser_err;
      if (byte_valid) begin
        if (byte_dc) begin
          wr_en       <= 1'b1;
          wr_data     <= rx_byte;
          wr_page     <= page;
          wr_col      <= col;
          arg_pending <= 1'b0;
          frame_done  <= (page == PAGE_LAST) && (col == COL_LAST);
          if (col == COL_LAST) begin
            col  <= '0;
            page <= (page == PAGE_LAST) ? '0 : page + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end else begin
          cmd_valid <= 1'b1;
          cmd_byte  <= rx_byte;
          // The byte after SET_PAGE is its argument, whatever its value.
          if (arg_pending) begin
            page        <= rx_byte[PAGE_W-1:0];
            arg_pending <= 1'b0;
          end else if (rx_byte == OLED_CMD_SET_PAGE) begin
            arg_pending <= 1'b1;
          end else if (rx_byte[7:4] == OLED_CMD_COL_LO) begin
            col[3:0] <= rx_byte[3:0];
          end else if (rx_byte[7:3] == {OLED_CMD_COL_HI, 1'b0}) begin
            col[6:4] <= rx_byte[2:0];
          end else if (rx_byte[7:3] == OLED_CMD_PAGE_BASE && !rx_byte[2]) begin
            page <= rx_byte[PAGE_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Bench for oled_spi_receiver: drives the SPI+DC link from directed byte
// sequences and checks every output pulse against a framebuffer-address model.
module tb_oled_spi_receiver;
  import oled_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int COLS        = 128;
  localparam int PAGES       = 4;
  localparam int LAT         = SYNC_STAGES + 2;
  localparam int W           = 29;

  logic CLK = 1'b0, RST = 1'b1, CS = 1'b1, SCLK = 1'b1, SDO = 1'b0, DC = 1'b0;
  logic wr_en, cmd_valid, frame_done, err_abort;
  logic [1:0] wr_page;
  logic [6:0] wr_col;
  logic [7:0] wr_data, cmd_byte;
  deser_state_t deser_state;

  oled_spi_receiver #(.SYNC_STAGES(SYNC_STAGES), .COLS(COLS), .PAGES(PAGES)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .SCLK(SCLK), .SDO(SDO), .DC(DC),
    .wr_en(wr_en), .wr_page(wr_page), .wr_col(wr_col), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .frame_done(frame_done),
    .err_abort(err_abort), .deser_state(deser_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int last_rise_cyc = 0;
  int fd_cnt = 0;
  logic [16:0] last_wr = '0;

  // model: current address and pending page argument
  int mpage = 0, mcol = 0;
  bit marg = 0;

  function automatic logic [W-1:0] ev(logic e, logic c, logic w, logic f, logic [1:0] p,
                                      logic [6:0] cl, logic [7:0] d, logic [7:0] cb);
    return {e, c, w, f, p, cl, d, cb};
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    mpage = 0; mcol = 0; marg = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic dc_v);
    int lin;
    if (dc_v) begin
      exp_q.push_back(ev(1'b0, 1'b0, 1'b1, (mpage == PAGES-1) && (mcol == COLS-1),
                         2'(mpage), 7'(mcol), b, 8'h00));
      lin   = (mpage * COLS + mcol + 1) % (PAGES * COLS);
      mpage = lin / COLS;
      mcol  = lin % COLS;
      marg  = 0;
    end else begin
      exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 7'd0, 8'd0, b));
      if (marg) begin
        mpage = b % PAGES;
        marg  = 0;
      end else if (b == 8'h22) marg = 1;
      else if (b <= 8'h0F) mcol = (mcol / 16) * 16 + (b % 16);
      else if (b >= 8'h10 && b <= 8'h17) mcol = (mcol % 16) + (b - 8'h10) * 16;
      else if (b >= 8'hB0 && b <= 8'hB3) mpage = b - 8'hB0;
    end
  endtask

  // driver
  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic shift_bits(input logic [7:0] b, input logic dc_v, input int half, input int nbits);
    for (int i = 7; i >= 8 - nbits; i--) begin
      SCLK = 1'b0; SDO = b[i]; DC = dc_v;
      wait_clk(half);
      SCLK = 1'b1;
      if (i == 0) last_rise_cyc = cyc;
      wait_clk(half);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc_v, input int half);
    model_byte(b, dc_v);
    CS = 1'b0;
    wait_clk(4);
    shift_bits(b, dc_v, half, 8);
    CS = 1'b1;
    wait_clk(4);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) @(negedge CLK);
    check(name, exp_q.size(), 0);
  endtask

  // compare process: every output pulse is matched against the expected queue
  always @(negedge CLK) begin
    logic [W-1:0] obs, e;
    if (wr_en || cmd_valid || err_abort || frame_done) begin
      obs = ev(err_abort, cmd_valid, wr_en, frame_done,
               wr_en ? wr_page : 2'd0, wr_en ? wr_col : 7'd0,
               wr_en ? wr_data : 8'd0, cmd_valid ? cmd_byte : 8'd0);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse got=%h required=none", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_bad++;
          $display("FAIL event got=%h required=%h", obs, e);
        end
      end
      if (wr_en || cmd_valid) begin
        n_cmp++;
        if (cyc - last_rise_cyc != LAT) begin
          n_bad++;
          $display("FAIL latency got=%0d required=%0d", cyc - last_rise_cyc, LAT);
        end
      end
      if (wr_en) last_wr = {wr_page, wr_col, wr_data};
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    // reset state
    wait_clk(4);
    RST = 1'b0;
    wait_clk(1);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_err_abort", int'(err_abort), 0);
    check("rst_outputs", int'({wr_page, wr_col, wr_data, cmd_byte}), 0);
    wait_clk(4);

    // 1: set page 2, column 0, write A5
    send_byte(8'h22, 1'b0, 4);
    send_byte(8'h02, 1'b0, 4);
    send_byte(8'h00, 1'b0, 4);
    send_byte(8'h10, 1'b0, 4);
    send_byte(8'hA5, 1'b1, 4);
    drain("t1_drain");
    check("t1_write", int'(last_wr), int'({2'd2, 7'd0, 8'hA5}));

    // 2: full frame from page0 col0, then one more write lands at 0,0
    send_byte(8'hB0, 1'b0, 3);
    send_byte(8'h00, 1'b0, 3);
    send_byte(8'h10, 1'b0, 3);
    fd_cnt = 0;
    for (int i = 0; i < PAGES * COLS; i++) send_byte(8'(i) ^ 8'h5A, 1'b1, 3);
    drain("t2_drain");
    check("t2_frame_done_count", fd_cnt, 1);
    check("t2_last_write", int'(last_wr), int'({2'd3, 7'd127, 8'hFF ^ 8'h5A}));
    send_byte(8'hC3, 1'b1, 3);
    drain("t2_wrap_drain");
    check("t2_wrap_write", int'(last_wr), int'({2'd0, 7'd0, 8'hC3}));

    // 3: CS rises after 5 bits, then a full data byte
    CS = 1'b0;
    wait_clk(4);
    shift_bits(8'hF0, 1'b1, 4, 5);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 7'd0, 8'd0, 8'd0));
    CS = 1'b1;
    wait_clk(4);
    send_byte(8'h3C, 1'b1, 4);
    drain("t3_drain");
    check("t3_write", int'(last_wr), int'({2'd0, 7'd1, 8'h3C}));

    // 4: column 0x35 via low/high nibble, then page 1 via B1
    send_byte(8'h05, 1'b0, 4);
    send_byte(8'h13, 1'b0, 4);
    send_byte(8'h11, 1'b1, 4);
    drain("t4a_drain");
    check("t4_model_col", mcol, 8'h36);
    check("t4a_write", int'(last_wr), int'({2'd0, 7'h35, 8'h11}));
    send_byte(8'hB1, 1'b0, 4);
    send_byte(8'h44, 1'b1, 4);
    drain("t4b_drain");
    check("t4b_write", int'(last_wr), int'({2'd1, 7'h36, 8'h44}));

    // 5: data after 0x22 clears the pending argument; 02 then sets col low nibble
    send_byte(8'h22, 1'b0, 4);
    send_byte(8'h7E, 1'b1, 4);
    send_byte(8'h02, 1'b0, 4);
    send_byte(8'h99, 1'b1, 4);
    drain("t5_drain");
    check("t5_write", int'(last_wr), int'({2'd1, 7'h32, 8'h99}));

    // 6: reset mid-byte with CS still low, then a fresh byte
    CS = 1'b0;
    wait_clk(4);
    shift_bits(8'hFF, 1'b1, 4, 4);
    RST = 1'b1;
    wait_clk(2);
    RST = 1'b0;
    model_reset();
    shift_bits(8'hFF, 1'b1, 4, 4);
    CS = 1'b1;
    wait_clk(6);
    send_byte(8'h55, 1'b1, 4);
    drain("t6_drain");
    check("t6_write", int'(last_wr), int'({2'd0, 7'd0, 8'h55}));

    wait_clk(20);
    check("queue_empty_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
